cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter WIDTH, default 31: result MSB index (32-bit results).
REQ-002 Parameter ROB, default 2: ROB tag MSB index (8-entry ROB).
REQ-003 Parameter NFU, default 3: number of functional-unit requesters (0=ALU, 1=BRANCH, 2=LSU).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  mispredict flush; discards all pending and in-flight results.
REQ-007 fuValid  input  [NFU-1:0]  requester i presents a finished result.
REQ-008 fuResult  input  [NFU-1:0][WIDTH:0]  result value per requester.
REQ-009 fuRob  input  [NFU-1:0][ROB:0]  destination ROB tag per requester.
REQ-010 fuReady  output  [NFU-1:0]  requester i's buffer can accept this cycle.
REQ-011 dataBus  commonDataBus.arbiter modport  drives validBroadcast, robEntry[ROB:0], result[WIDTH:0], read by the rename stage and reservation stations.
REQ-012 grant  output  [NFU-1:0]  one-hot source of the current broadcast; all-zero when validBroadcast=0.

Function
REQ-013 Each requester SHALL own a 2-entry FIFO (1-bit wr/rd pointers, 2-bit count 0..2).
REQ-014 fuReady[i] SHALL be (count[i] < 2) & ~flush, derived from registered state only.
REQ-015 Enqueue of {fuRob[i], fuResult[i]} SHALL occur on an edge where fuValid[i] & fuReady[i]; fuValid without fuReady is ignored, and the requester holds.
REQ-016 An entry enqueued at edge N SHALL be eligible for arbitration in the cycle after edge N, never in the cycle it is presented (no bypass).
REQ-017 Arbitration SHALL be round-robin among non-empty FIFOs, searching from pointer rrPtr upward modulo NFU.
REQ-018 The winner's head entry SHALL be dequeued and loaded into the broadcast register at the same edge; at most one dequeue per cycle.
REQ-019 After a grant to source i, rrPtr SHALL become (i+1) mod NFU; with no grant, rrPtr is unchanged.
REQ-020 Broadcast outputs SHALL be registered: validBroadcast, robEntry, result and grant reflect the edge-N winner throughout cycle N+1; minimum accept-to-broadcast latency 2 cycles.
REQ-021 With all FIFOs empty, validBroadcast SHALL be 0 next cycle, and robEntry/result hold their last values (don't-care).
REQ-022 A simultaneous enqueue and dequeue on the same FIFO (count 1) SHALL leave count 1; a simultaneous enqueue and dequeue at count 0 is impossible per REQ-016.
REQ-023 Pointer wrap: FIFO pointers SHALL wrap 1->0; rrPtr wraps NFU-1->0.
REQ-024 A flush-high edge SHALL zero every FIFO count/pointer and validBroadcast/grant, accept nothing, and leave rrPtr unchanged; flush has priority over enqueue and dequeue.
REQ-025 The arbiter SHALL not inspect or reorder ROB tags; per-source FIFO order is preserved, and cross-source order follows grants.

Reset
REQ-026 A reset-high edge SHALL set all FIFO counts/pointers 0, validBroadcast 0, grant 0, robEntry 0, result 0, rrPtr 0; fuReady is 0 while reset is high.
REQ-027 Reset SHALL override flush and all handshakes, including a reset arriving mid-broadcast.

Structure
REQ-028 NFU, FU index constants (FU_ALU, FU_BRANCH, FU_LSU) and the cdb_entry_t typedef {rob tag, result} SHALL live in the shared core package.
REQ-029 The per-requester FIFO SHALL be a sub-module, cdb_fu_fifo, instantiated NFU times; commonDataBus gains the arbiter modport.

Verification
REQ-030 Single request: after reset, ALU presents rob=3, result=0x0000_00AA for 1 cycle -> accepted; validBroadcast=1, robEntry=3, result=0xAA, grant=001 exactly 2 cycles later, then validBroadcast=0.
REQ-031 Fairness: all three present continuously (rob 1/2/3) from rrPtr=0 -> grants 001,010,100,001... with no source starved and each FIFO order preserved.
REQ-032 Backpressure: BRANCH presents 4 back-to-back results while ALU and LSU saturate the bus -> fuReady[1] drops once count=2, and all 4 broadcast in order with no loss or duplication.
REQ-033 Flush: 2 entries queued in each FIFO plus a valid broadcast, flush pulsed 1 cycle -> next cycle validBroadcast=0, fuReady=111, and no stale tag is ever broadcast.
REQ-034 Reset mid-operation: reset asserted while LSU FIFO full and a broadcast active -> next cycle all outputs 0, rrPtr=0, and a first post-reset request follows REQ-030 timing.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared core constants and the common-data-bus entry type.
// Functional-unit indices and the default bus geometry live here.
package cdb_arbiter_pkg;

  localparam int CDB_WIDTH = 31;
  localparam int CDB_ROB   = 2;
  localparam int NFU       = 3;

  localparam int FU_ALU    = 0;
  localparam int FU_BRANCH = 1;
  localparam int FU_LSU    = 2;

  typedef struct packed {
    logic [CDB_ROB:0]   rob;
    logic [CDB_WIDTH:0] result;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_common_data_bus.sv
// Common data bus carrying one completed result per cycle to rename and the
// reservation stations; the arbiter is the only driver.
interface commonDataBus #(
  parameter int WIDTH = 31,
  parameter int ROB   = 2
);
  logic           validBroadcast;
  logic [ROB:0]   robEntry;
  logic [WIDTH:0] result;

  modport arbiter  (output validBroadcast, robEntry, result);
  modport consumer (input  validBroadcast, robEntry, result);
endinterface

// File: rtl/cdb_fu_fifo.sv
// Two-entry per-requester result buffer. The head is only visible after the
// entry has been written, so a result is never granted in its arrival cycle.
module cdb_fu_fifo #(
  parameter int DW = 35
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          ready,
  output logic          empty,
  output logic [DW-1:0] head
);

  logic [1:0]    count;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [DW-1:0] mem [2];

  assign ready = (count < 2'd2) & ~flush & ~reset;
  assign empty = (count == 2'd0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that picks one buffered functional-unit result per cycle
// and broadcasts it on the common data bus from a register.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int WIDTH = CDB_WIDTH,
  parameter int ROB   = CDB_ROB,
  parameter int NFU   = cdb_arbiter_pkg::NFU
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NFU-1:0]            fuValid,
  input  logic [NFU-1:0][WIDTH:0]   fuResult,
  input  logic [NFU-1:0][ROB:0]     fuRob,
  output logic [NFU-1:0]            fuReady,
  commonDataBus.arbiter             dataBus,
  output logic [NFU-1:0]            grant
);

  localparam int DW = ROB + WIDTH + 2;
  localparam int PW = (NFU > 1) ? $clog2(NFU) : 1;

  logic [NFU-1:0] empty;
  logic [NFU-1:0] pop;
  logic [DW-1:0]  head [NFU];
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  cand;
  logic [PW-1:0]  win_idx;
  logic           win_any;
  logic           valid_q;
  logic [ROB:0]   rob_q;
  logic [WIDTH:0] result_q;

  for (genvar i = 0; i < NFU; i++) begin : g_fifo
    cdb_fu_fifo #(.DW(DW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (fuValid[i] & fuReady[i]),
      .pop   (pop[i]),
      .din   ({fuRob[i], fuResult[i]}),
      .ready (fuReady[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
    assign pop[i] = win_any && (win_idx == PW'(i)) && !flush;
  end

  // First non-empty buffer at or after rr_ptr, wrapping at NFU.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    cand    = rr_ptr;
    for (int k = 0; k < NFU; k++) begin
      if (!win_any && !empty[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
      cand = (cand == PW'(NFU - 1)) ? '0 : cand + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      grant    <= '0;
      rob_q    <= '0;
      result_q <= '0;
      rr_ptr   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      grant   <= '0;
    end else begin
      valid_q <= win_any;
      grant   <= pop;
      if (win_any) begin
        {rob_q, result_q} <= head[win_idx];
        rr_ptr            <= (win_idx == PW'(NFU - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  assign dataBus.validBroadcast = valid_q;
  assign dataBus.robEntry       = rob_q;
  assign dataBus.result         = result_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: single request latency, round-robin fairness,
// backpressure, flush and mid-operation reset, with per-source expected queues.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int W = 31;
  localparam int R = 2;
  localparam int N = 3;

  logic                 clk;
  logic                 reset;
  logic                 flush;
  logic [N-1:0]         fuValid;
  logic [N-1:0][W:0]    fuResult;
  logic [N-1:0][R:0]    fuRob;
  logic [N-1:0]         fuReady;
  logic [N-1:0]         grant;

  commonDataBus #(.WIDTH(W), .ROB(R)) bus ();

  cdb_arbiter #(.WIDTH(W), .ROB(R), .NFU(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .fuValid  (fuValid),
    .fuResult (fuResult),
    .fuRob    (fuRob),
    .fuReady  (fuReady),
    .dataBus  (bus.arbiter),
    .grant    (grant)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  cdb_entry_t exp_q0[$];
  cdb_entry_t exp_q1[$];
  cdb_entry_t exp_q2[$];
  int         src_left[N];
  int         seq[N];
  int         n_src[N];
  int         rot_left;
  logic [N-1:0] exp_g;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    for (int i = 0; i < N; i++) begin
      src_left[i] = 0;
      n_src[i]    = 0;
    end
    rot_left = 0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    flush   = 1'b0;
    fuValid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    clear_model();
  endtask

  // One cycle: score the current broadcast, drive requesters, advance past the edge.
  task automatic cycle_step();
    logic [N-1:0] acc;
    cdb_entry_t   got;
    cdb_entry_t   exp;
    logic         pend;
    int           s;
    if (bus.validBroadcast) begin
      got  = {bus.robEntry, bus.result};
      exp  = '0;
      pend = 1'b0;
      s    = -1;
      check("grant_onehot", 64'($onehot(grant)), 64'd1);
      for (int i = 0; i < N; i++) if (grant == N'(1 << i)) s = i;
      if (rot_left > 0) begin
        check("rr_grant", 64'(grant), 64'(exp_g));
        exp_g = {exp_g[N-2:0], exp_g[N-1]};
        rot_left--;
      end
      if (s == 0 && exp_q0.size() > 0) begin pend = 1'b1; exp = exp_q0.pop_front(); end
      if (s == 1 && exp_q1.size() > 0) begin pend = 1'b1; exp = exp_q1.pop_front(); end
      if (s == 2 && exp_q2.size() > 0) begin pend = 1'b1; exp = exp_q2.pop_front(); end
      check("bcast_pending", 64'(pend), 64'd1);
      if (pend) begin
        check("bcast_data", 64'(got), 64'(exp));
        n_src[s]++;
      end
    end else begin
      check("idle_grant", 64'(grant), 64'd0);
    end
    for (int i = 0; i < N; i++) begin
      fuValid[i]  = (src_left[i] > 0);
      fuRob[i]    = R'(i + 1);
      fuResult[i] = 32'h100 * (i + 1) + seq[i];
    end
    #1;
    acc = fuValid & fuReady;
    if (acc[0]) exp_q0.push_back({fuRob[0], fuResult[0]});
    if (acc[1]) exp_q1.push_back({fuRob[1], fuResult[1]});
    if (acc[2]) exp_q2.push_back({fuRob[2], fuResult[2]});
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        src_left[i]--;
        seq[i]++;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((src_left[0] + src_left[1] + src_left[2] > 0 ||
            exp_q0.size() + exp_q1.size() + exp_q2.size() > 0) && n < budget) begin
      cycle_step();
      n++;
    end
    check("drain_done", 64'(n < budget), 64'd1);
  endtask

  // Present ALU (rob 3, 0xAA) and optionally BRANCH (rob 5, 0x55) for one cycle.
  task automatic single_request(input logic with_branch);
    fuValid     = with_branch ? 3'b011 : 3'b001;
    fuRob[0]    = 3'd3;
    fuResult[0] = 32'h0000_00AA;
    fuRob[1]    = 3'd5;
    fuResult[1] = 32'h0000_0055;
    @(posedge clk); #1;
    fuValid = '0;
    check("sr_not_bypassed", 64'(bus.validBroadcast), 64'd0);
    @(posedge clk); #1;
    check("sr_valid", 64'(bus.validBroadcast), 64'd1);
    check("sr_rob", 64'(bus.robEntry), 64'd3);
    check("sr_result", 64'(bus.result), 64'hAA);
    check("sr_grant", 64'(grant), 64'b001);
    if (with_branch) begin
      @(posedge clk); #1;
      check("sr2_grant", 64'(grant), 64'b010);
      check("sr2_rob", 64'(bus.robEntry), 64'd5);
      check("sr2_result", 64'(bus.result), 64'h55);
    end
    @(posedge clk); #1;
    check("sr_idle_valid", 64'(bus.validBroadcast), 64'd0);
    check("sr_idle_grant", 64'(grant), 64'd0);
    check("sr_hold_result", 64'(bus.result), with_branch ? 64'h55 : 64'hAA);
  endtask

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    fuValid  = '0;
    fuResult = '0;
    fuRob    = '0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    clear_model();

    // reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_valid", 64'(bus.validBroadcast), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_rob", 64'(bus.robEntry), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_ready", 64'(fuReady), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 64'(fuReady), 64'b111);

    // single request, 2-cycle latency
    single_request(1'b0);

    // fairness from rr_ptr = 0
    do_reset();
    for (int i = 0; i < N; i++) src_left[i] = 12;
    exp_g    = 3'b001;
    rot_left = 12;
    drain(200);
    check("fair_alu", 64'(n_src[0]), 64'd12);
    check("fair_branch", 64'(n_src[1]), 64'd12);
    check("fair_lsu", 64'(n_src[2]), 64'd12);

    // backpressure on BRANCH while ALU and LSU saturate
    do_reset();
    src_left[0] = 8;
    src_left[1] = 4;
    src_left[2] = 8;
    cycle_step();
    cycle_step();
    check("bp_ready", 64'(fuReady), 64'b001);
    drain(200);
    check("bp_branch_cnt", 64'(n_src[1]), 64'd4);
    check("bp_alu_cnt", 64'(n_src[0]), 64'd8);

    // flush with buffered entries and a live broadcast
    do_reset();
    for (int i = 0; i < N; i++) src_left[i] = 5;
    cycle_step();
    cycle_step();
    cycle_step();
    check("fl_pre_valid", 64'(bus.validBroadcast), 64'd1);
    flush = 1'b1;
    #1;
    check("fl_ready_low", 64'(fuReady), 64'd0);
    cycle_step();
    flush   = 1'b0;
    fuValid = '0;
    #1;
    check("fl_valid", 64'(bus.validBroadcast), 64'd0);
    check("fl_grant", 64'(grant), 64'd0);
    check("fl_ready", 64'(fuReady), 64'b111);
    clear_model();
    for (int k = 0; k < 4; k++) cycle_step();
    check("fl_no_stale", 64'(n_src[0] + n_src[1] + n_src[2]), 64'd0);
    // last grant before flush was BRANCH, so LSU is searched first
    src_left[0] = 1;
    src_left[2] = 1;
    exp_g       = 3'b100;
    rot_left    = 2;
    drain(20);
    check("fl_rr_kept", 64'(rot_left), 64'd0);

    // reset during a broadcast with the LSU buffer full
    do_reset();
    src_left[0] = 1;
    src_left[2] = 3;
    cycle_step();
    cycle_step();
    check("mr_bcast", 64'(bus.validBroadcast), 64'd1);
    check("mr_lsu_full", 64'(fuReady), 64'b011);
    reset = 1'b1;
    flush = 1'b1;
    #1;
    check("mr_ready_low", 64'(fuReady), 64'd0);
    @(posedge clk); #1;
    reset   = 1'b0;
    flush   = 1'b0;
    fuValid = '0;
    #1;
    clear_model();
    check("mr_valid", 64'(bus.validBroadcast), 64'd0);
    check("mr_grant", 64'(grant), 64'd0);
    check("mr_rob", 64'(bus.robEntry), 64'd0);
    check("mr_result", 64'(bus.result), 64'd0);
    check("mr_ready", 64'(fuReady), 64'b111);
    single_request(1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
